// File: rtl/bf_pkg.sv
// bf_pkg: shared definitions for the stacked Brainfuck core.
//   - opcode byte values recognised by the core
//   - core state enumeration
//   - bus strobe encoding (one value per one-hot transaction strobe)
package bf_pkg;

  localparam int OPCODE_WIDTH = 8;

  localparam logic [OPCODE_WIDTH-1:0] OP_INC   = 8'h2B;  // '+'
  localparam logic [OPCODE_WIDTH-1:0] OP_DEC   = 8'h2D;  // '-'
  localparam logic [OPCODE_WIDTH-1:0] OP_RIGHT = 8'h3E;  // '>'
  localparam logic [OPCODE_WIDTH-1:0] OP_LEFT  = 8'h3C;  // '<'
  localparam logic [OPCODE_WIDTH-1:0] OP_OUT   = 8'h2E;  // '.'
  localparam logic [OPCODE_WIDTH-1:0] OP_IN    = 8'h2C;  // ','
  localparam logic [OPCODE_WIDTH-1:0] OP_LOOP  = 8'h5B;  // '['
  localparam logic [OPCODE_WIDTH-1:0] OP_END   = 8'h5D;  // ']'
  localparam logic [OPCODE_WIDTH-1:0] OP_HALT  = 8'h00;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_FETCH,
    ST_EXEC,
    ST_WRITEBACK,
    ST_IOOUT,
    ST_IOIN,
    ST_SCAN,
    ST_HALT
  } bf_state_t;

  typedef enum logic [2:0] {
    STB_NONE,
    STB_READ_PROG,
    STB_READ_DATA,
    STB_WRITE_DATA,
    STB_READ_IO,
    STB_WRITE_IO
  } bf_strobe_t;

endpackage

// File: rtl/bf_loop_stack.sv
// bf_loop_stack: LIFO of loop-start addresses.
// Ports:
//   i_clock    clock, rising edge
//   i_reset_n  asynchronous active-low reset (empties the stack)
//   i_push     push i_data (ignored when full)
//   i_pop      drop the top entry (ignored when empty)
//   i_data     address to push
//   o_top      current top entry ('0 when empty)
//   o_full     LOOP_DEPTH entries held
//   o_empty    no entries held
// A push and pop in the same cycle overwrite the top entry in place.
module bf_loop_stack #(
  parameter int ADDR_WIDTH = 15,
  parameter int LOOP_DEPTH = 16
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [ADDR_WIDTH-1:0] i_data,
  output logic [ADDR_WIDTH-1:0] o_top,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int CNT_W = $clog2(LOOP_DEPTH + 1);
  localparam int IDX_W = $clog2(LOOP_DEPTH);

  logic [ADDR_WIDTH-1:0] r_mem [LOOP_DEPTH];
  logic [CNT_W-1:0]      r_count;

  logic [IDX_W-1:0] w_top_idx;
  logic [IDX_W-1:0] w_wr_idx;
  logic             w_replace;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(LOOP_DEPTH));
  assign w_top_idx = IDX_W'(r_count - 1'b1);

  assign w_replace = i_push && i_pop && !o_empty;
  assign w_do_push = i_push && !w_replace && !o_full;
  assign w_do_pop  = i_pop && !i_push && !o_empty;
  assign w_wr_idx  = w_replace ? w_top_idx : IDX_W'(r_count);

  assign o_top = o_empty ? '0 : r_mem[w_top_idx];

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else if (w_do_push) begin
      r_count <= r_count + 1'b1;
    end else if (w_do_pop) begin
      r_count <= r_count - 1'b1;
    end
  end

  // Entry storage needs no reset: r_count decides which entries are live.
  always_ff @(posedge i_clock) begin
    if (w_do_push || w_replace) begin
      r_mem[w_wr_idx] <= i_data;
    end
  end

endmodule

// File: rtl/bf_core_stacked.sv
// bf_core_stacked: Brainfuck interpreter core with cached data cell and a
// hardware loop stack.
// Ports:
//   clock       clock, rising edge
//   reset       asynchronous active-low reset
//   addr        bus address (pc for program reads, cursor for data access)
//   val_out     write data (current cell)
//   val_in      read data, sampled when valid=1
//   valid       completes the outstanding transaction
//   read_prog / read_data / write_data / read_io / write_io
//               one-hot transaction strobes, held until valid
//   halted      core stopped (sticky)
//   error       abnormal halt (sticky)
//   enable      run permission, looked at while idle in Fetch
module bf_core_stacked
  import bf_pkg::*;
#(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 8,
  parameter int LOOP_DEPTH = 16,
  parameter int NEST_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] val_out,
  input  logic [DATA_WIDTH-1:0] val_in,
  input  logic                  valid,
  output logic                  read_prog,
  output logic                  read_data,
  output logic                  write_data,
  output logic                  read_io,
  output logic                  write_io,
  output logic                  halted,
  output logic                  error,
  input  logic                  enable
);

  bf_state_t               r_state;
  logic [ADDR_WIDTH-1:0]   r_pc;
  logic [ADDR_WIDTH-1:0]   r_cursor;
  logic [DATA_WIDTH-1:0]   r_cell;
  logic                    r_dirty;
  logic [OPCODE_WIDTH-1:0] r_instr;
  logic [NEST_WIDTH-1:0]   r_nest;
  logic                    r_error;
  logic                    r_started;     // keeps strobes low while in/just out of reset
  logic                    r_fetch_busy;  // a program read is in flight; enable no longer matters
  logic                    r_scan_gap;    // one idle cycle between back-to-back scan reads

  bf_state_t               w_state_next;
  logic [ADDR_WIDTH-1:0]   w_pc_next;
  logic [ADDR_WIDTH-1:0]   w_cursor_next;
  logic [DATA_WIDTH-1:0]   w_cell_next;
  logic                    w_dirty_next;
  logic [OPCODE_WIDTH-1:0] w_instr_next;
  logic [NEST_WIDTH-1:0]   w_nest_next;
  logic                    w_error_next;
  logic                    w_fetch_busy_next;
  logic                    w_scan_gap_next;

  bf_strobe_t              w_strobe;
  logic                    w_done;
  logic                    w_push;
  logic                    w_pop;
  logic [ADDR_WIDTH-1:0]   w_top;
  logic                    w_full;
  logic                    w_empty;
  logic [ADDR_WIDTH-1:0]   w_pc_inc;
  logic [ADDR_WIDTH-1:0]   w_cursor_moved;
  logic [OPCODE_WIDTH-1:0] w_byte_in;
  logic                    w_cell_zero;

  bf_loop_stack #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .LOOP_DEPTH(LOOP_DEPTH)
  ) u_stack (
    .i_clock  (clock),
    .i_reset_n(reset),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .i_data   (r_pc),
    .o_top    (w_top),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  assign w_pc_inc       = r_pc + 1'b1;
  assign w_cursor_moved = (r_instr == OP_RIGHT) ? r_cursor + 1'b1 : r_cursor - 1'b1;
  assign w_byte_in      = val_in[OPCODE_WIDTH-1:0];
  assign w_cell_zero    = (r_cell == '0);
  assign w_done         = valid && (w_strobe != STB_NONE);

  // State register and datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_LOAD;
      r_pc         <= '0;
      r_cursor     <= '0;
      r_cell       <= '0;
      r_dirty      <= 1'b0;
      r_instr      <= '0;
      r_nest       <= '0;
      r_error      <= 1'b0;
      r_started    <= 1'b0;
      r_fetch_busy <= 1'b0;
      r_scan_gap   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_pc         <= w_pc_next;
      r_cursor     <= w_cursor_next;
      r_cell       <= w_cell_next;
      r_dirty      <= w_dirty_next;
      r_instr      <= w_instr_next;
      r_nest       <= w_nest_next;
      r_error      <= w_error_next;
      r_started    <= 1'b1;
      r_fetch_busy <= w_fetch_busy_next;
      r_scan_gap   <= w_scan_gap_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next      = r_state;
    w_pc_next         = r_pc;
    w_cursor_next     = r_cursor;
    w_cell_next       = r_cell;
    w_dirty_next      = r_dirty;
    w_instr_next      = r_instr;
    w_nest_next       = r_nest;
    w_error_next      = r_error;
    w_fetch_busy_next = 1'b0;
    w_scan_gap_next   = 1'b0;
    w_push            = 1'b0;
    w_pop             = 1'b0;
    case (r_state)
      ST_LOAD: begin
        if (w_done) begin
          w_cell_next  = val_in;
          w_dirty_next = 1'b0;
          w_state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        w_fetch_busy_next = read_prog && !valid;
        if (w_done) begin
          w_instr_next = w_byte_in;
          w_state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (r_instr)
          OP_INC, OP_DEC: begin
            w_cell_next  = (r_instr == OP_INC) ? r_cell + 1'b1 : r_cell - 1'b1;
            w_dirty_next = 1'b1;
            w_pc_next    = w_pc_inc;
            w_state_next = ST_FETCH;
          end
          OP_RIGHT, OP_LEFT: begin
            // A dirty cell is flushed first; WriteBack then performs the move.
            if (r_dirty) begin
              w_state_next = ST_WRITEBACK;
            end else begin
              w_cursor_next = w_cursor_moved;
              w_pc_next     = w_pc_inc;
              w_state_next  = ST_LOAD;
            end
          end
          OP_OUT: w_state_next = ST_IOOUT;
          OP_IN:  w_state_next = ST_IOIN;
          OP_LOOP: begin
            if (w_cell_zero) begin
              w_nest_next  = NEST_WIDTH'(1);
              w_pc_next    = w_pc_inc;
              w_state_next = ST_SCAN;
            end else if (w_full) begin
              w_error_next = 1'b1;
              w_state_next = ST_HALT;
            end else begin
              w_push       = 1'b1;
              w_pc_next    = w_pc_inc;
              w_state_next = ST_FETCH;
            end
          end
          OP_END: begin
            if (w_empty) begin
              w_error_next = 1'b1;
              w_state_next = ST_HALT;
            end else if (!w_cell_zero) begin
              w_pc_next    = w_top + 1'b1;
              w_state_next = ST_FETCH;
            end else begin
              w_pop        = 1'b1;
              w_pc_next    = w_pc_inc;
              w_state_next = ST_FETCH;
            end
          end
          OP_HALT: w_state_next = r_dirty ? ST_WRITEBACK : ST_HALT;
          default: begin
            w_pc_next    = w_pc_inc;
            w_state_next = ST_FETCH;
          end
        endcase
      end
      ST_WRITEBACK: begin
        // r_instr still holds the instruction that requested the flush.
        if (w_done) begin
          w_dirty_next = 1'b0;
          if (r_instr == OP_HALT) begin
            w_state_next = ST_HALT;
          end else begin
            w_cursor_next = w_cursor_moved;
            w_pc_next     = w_pc_inc;
            w_state_next  = ST_LOAD;
          end
        end
      end
      ST_IOOUT: begin
        if (w_done) begin
          w_pc_next    = w_pc_inc;
          w_state_next = ST_FETCH;
        end
      end
      ST_IOIN: begin
        if (w_done) begin
          w_cell_next  = val_in;
          w_dirty_next = 1'b1;
          w_pc_next    = w_pc_inc;
          w_state_next = ST_FETCH;
        end
      end
      ST_SCAN: begin
        if (w_done) begin
          w_scan_gap_next = 1'b1;
          if (w_byte_in == OP_LOOP) begin
            if (&r_nest) begin
              w_error_next = 1'b1;
              w_state_next = ST_HALT;
            end else begin
              w_nest_next = r_nest + 1'b1;
              w_pc_next   = w_pc_inc;
            end
          end else if (w_byte_in == OP_END) begin
            w_nest_next = r_nest - 1'b1;
            w_pc_next   = w_pc_inc;
            if (r_nest == NEST_WIDTH'(1)) begin
              w_state_next = ST_FETCH;
            end
          end else if (w_byte_in == OP_HALT) begin
            w_error_next = 1'b1;
            w_state_next = ST_HALT;
          end else begin
            w_pc_next = w_pc_inc;
          end
        end
      end
      default: w_state_next = ST_HALT;
    endcase
  end

  // Output logic: strobe selection and bus drive.
  always_comb begin
    w_strobe = STB_NONE;
    if (r_started) begin
      case (r_state)
        ST_LOAD:      w_strobe = STB_READ_DATA;
        ST_FETCH:     if (enable || r_fetch_busy) w_strobe = STB_READ_PROG;
        ST_WRITEBACK: w_strobe = STB_WRITE_DATA;
        ST_IOOUT:     w_strobe = STB_WRITE_IO;
        ST_IOIN:      w_strobe = STB_READ_IO;
        ST_SCAN:      if (!r_scan_gap) w_strobe = STB_READ_PROG;
        default:      w_strobe = STB_NONE;
      endcase
    end
  end

  assign read_prog  = (w_strobe == STB_READ_PROG);
  assign read_data  = (w_strobe == STB_READ_DATA);
  assign write_data = (w_strobe == STB_WRITE_DATA);
  assign read_io    = (w_strobe == STB_READ_IO);
  assign write_io   = (w_strobe == STB_WRITE_IO);
  assign addr       = read_prog ? r_pc : r_cursor;
  assign val_out    = r_cell;
  assign halted     = (r_state == ST_HALT);
  assign error      = r_error;

endmodule

// File: tb/tb_bf_core_stacked.sv
// Directed bench for bf_core_stacked (LOOP_DEPTH=2). A bus responder models
// program RAM, data RAM and the IO FIFO with per-strobe latency.
module tb_bf_core_stacked;

  localparam int AW = 15;
  localparam int DW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] addr;
  logic [DW-1:0] val_out;
  logic [DW-1:0] val_in;
  logic          valid;
  logic          read_prog, read_data, write_data, read_io, write_io;
  logic          halted, error;
  logic          enable = 1'b1;

  always #5 clock = ~clock;

  bf_core_stacked #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .LOOP_DEPTH(2),
    .NEST_WIDTH(8)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .addr      (addr),
    .val_out   (val_out),
    .val_in    (val_in),
    .valid     (valid),
    .read_prog (read_prog),
    .read_data (read_data),
    .write_data(write_data),
    .read_io   (read_io),
    .write_io  (write_io),
    .halted    (halted),
    .error     (error),
    .enable    (enable)
  );

  // Written by the main sequence only.
  logic [7:0]    prog [0:255];
  logic [7:0]    dpre [0:32767];
  int            lat_mem, lat_io, lat_wd;
  logic [7:0]    io_in_val;
  int            n_vec, n_err;

  // Written by the responder only.
  logic [7:0]    dwr [int];
  int            prog_rd_cnt;
  logic [AW-1:0] prog_trace [0:63];
  int            wd_cnt;
  logic [AW-1:0] wd_addr [0:7];
  logic [7:0]    wd_val [0:7];
  int            io_out_cnt;
  logic [7:0]    io_out_last;
  int            io_rd_cycles, io_rd_done;
  logic [AW-1:0] rd_addr_last;
  int            onehot_err, stab_err;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bus responder: decides valid at the falling edge, DUT samples at the rising edge.
  initial begin : responder
    int            wait_cnt;
    int            cur_lat;
    int            nstb;
    logic [AW-1:0] held_addr;
    logic [DW-1:0] held_val;
    wait_cnt = 0; valid = 1'b0; val_in = '0; held_addr = '0; held_val = '0;
    prog_rd_cnt = 0; wd_cnt = 0; io_out_cnt = 0; io_out_last = '0;
    io_rd_cycles = 0; io_rd_done = 0; rd_addr_last = '0;
    onehot_err = 0; stab_err = 0;
    forever begin
      @(negedge clock);
      valid = 1'b0;
      if (!reset) begin
        wait_cnt = 0;
        prog_rd_cnt = 0; wd_cnt = 0; io_out_cnt = 0; io_out_last = '0;
        io_rd_cycles = 0; io_rd_done = 0; rd_addr_last = '0;
        dwr.delete();
      end else begin
        nstb = int'(read_prog) + int'(read_data) + int'(write_data) + int'(read_io) + int'(write_io);
        if (nstb > 1) onehot_err++;
        if (nstb == 0) begin
          wait_cnt = 0;
        end else begin
          if (wait_cnt == 0) begin
            held_addr = addr;
            held_val  = val_out;
          end else if (addr !== held_addr || val_out !== held_val) begin
            stab_err++;
          end
          if (read_io) io_rd_cycles++;
          if (write_data)   cur_lat = lat_wd;
          else if (read_io) cur_lat = lat_io;
          else              cur_lat = lat_mem;
          if (wait_cnt >= cur_lat) begin
            valid    = 1'b1;
            wait_cnt = 0;
            if (read_prog) begin
              val_in = prog[addr[7:0]];
              if (prog_rd_cnt < 64) prog_trace[prog_rd_cnt] = addr;
              prog_rd_cnt++;
              $display("%0t read_prog  addr=%h data=%h", $time, addr, val_in);
            end else if (read_data) begin
              val_in = dwr.exists(int'(addr)) ? dwr[int'(addr)] : dpre[addr];
              rd_addr_last = addr;
              $display("%0t read_data  addr=%h data=%h", $time, addr, val_in);
            end else if (write_data) begin
              dwr[int'(addr)] = val_out;
              if (wd_cnt < 8) begin
                wd_addr[wd_cnt] = addr;
                wd_val[wd_cnt]  = val_out;
              end
              wd_cnt++;
              $display("%0t write_data addr=%h data=%h", $time, addr, val_out);
            end else if (read_io) begin
              val_in = io_in_val;
              io_rd_done++;
              $display("%0t read_io    data=%h", $time, val_in);
            end else begin
              io_out_cnt++;
              io_out_last = val_out;
              $display("%0t write_io   data=%h", $time, val_out);
            end
          end else begin
            wait_cnt++;
          end
        end
      end
    end
  end

  task automatic setup(input string p, input int lm, input int lio, input int lwd);
    @(negedge clock);
    reset = 1'b1;
    #1;
    reset = 1'b0;
    enable = 1'b1;
    lat_mem = lm; lat_io = lio; lat_wd = lwd;
    for (int i = 0; i < 256; i++) prog[i] = 8'h00;
    for (int i = 0; i < 32768; i++) dpre[i] = 8'h00;
    for (int i = 0; i < p.len(); i++) prog[i] = p[i];
    repeat (2) @(negedge clock);
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic run_to_halt(input string tag, input int budget);
    int n;
    n = 0;
    while (!halted && n < budget) begin
      @(negedge clock);
      n++;
    end
    check_val({tag, "_halted"}, halted, 1);
  endtask

  initial begin : main
    int n;
    n_vec = 0; n_err = 0;
    lat_mem = 0; lat_io = 0; lat_wd = 0; io_in_val = 8'h00;

    // "++." : single output of 2, writeback of dirty cell at halt.
    setup("++.", 0, 0, 0);
    check_val("rst_strobes", {read_prog, read_data, write_data, read_io, write_io}, 0);
    check_val("rst_halted", halted, 0);
    check_val("rst_error", error, 0);
    check_val("rst_addr", addr, 0);
    release_reset();
    run_to_halt("t1", 200);
    check_val("t1_error", error, 0);
    check_val("t1_io_cnt", io_out_cnt, 1);
    check_val("t1_io_val", io_out_last, 8'h02);
    check_val("t1_wd_cnt", wd_cnt, 1);
    check_val("t1_wd_addr", wd_addr[0], 0);
    check_val("t1_wd_val", wd_val[0], 8'h02);
    repeat (4) @(negedge clock);
    check_val("t1_halt_strobes", {read_prog, read_data, write_data, read_io, write_io}, 0);
    check_val("t1_halt_sticky", halted, 1);

    // "++[-]" : ']' branches back once to pc 3, then pops.
    setup("++[-]", 1, 0, 1);
    release_reset();
    run_to_halt("t2", 300);
    check_val("t2_error", error, 0);
    check_val("t2_prog_reads", prog_rd_cnt, 8);
    check_val("t2_loop_back_pc", prog_trace[5], 3);
    check_val("t2_wd_val", wd_val[0], 8'h00);

    // "++[-]]" : the second ']' finds the stack empty.
    setup("++[-]]", 0, 0, 0);
    release_reset();
    run_to_halt("t2b", 300);
    check_val("t2b_error", error, 1);
    check_val("t2b_wd_cnt", wd_cnt, 0);

    // "[+[+]+]." on a zero cell : scan pc 1..6, resume at pc 7.
    setup("[+[+]+].", 1, 0, 0);
    release_reset();
    run_to_halt("t3", 300);
    check_val("t3_error", error, 0);
    check_val("t3_prog_reads", prog_rd_cnt, 9);
    for (int i = 0; i < 9; i++) check_val($sformatf("t3_trace%0d", i), prog_trace[i], i);
    check_val("t3_io_val", io_out_last, 8'h00);
    check_val("t3_wd_cnt", wd_cnt, 0);

    // "[" on a zero cell : scan runs into 0x00.
    setup("[", 0, 0, 0);
    release_reset();
    run_to_halt("t3b", 100);
    check_val("t3b_error", error, 1);

    // "+<-." with cell0=5 : flush before move, cursor wraps to 0x7FFF, 0-1=0xFF.
    setup("+<-.", 2, 0, 2);
    dpre[0] = 8'h05;
    release_reset();
    run_to_halt("t4", 300);
    check_val("t4_error", error, 0);
    check_val("t4_rd_addr", rd_addr_last, 15'h7FFF);
    check_val("t4_wd_cnt", wd_cnt, 2);
    check_val("t4_wd0_addr", wd_addr[0], 0);
    check_val("t4_wd0_val", wd_val[0], 8'h06);
    check_val("t4_wd1_addr", wd_addr[1], 15'h7FFF);
    check_val("t4_wd1_val", wd_val[1], 8'hFF);
    check_val("t4_io_val", io_out_last, 8'hFF);

    // "+[[[" with two stack entries : third push overflows.
    setup("+[[[", 0, 0, 0);
    release_reset();
    run_to_halt("t5", 200);
    check_val("t5_error", error, 1);

    // "+[[-]]+[-]" : fill the stack, drain it, reuse it.
    setup("+[[-]]+[-]", 0, 0, 0);
    release_reset();
    run_to_halt("t5b", 300);
    check_val("t5b_error", error, 0);
    check_val("t5b_prog_reads", prog_rd_cnt, 11);

    // "]" alone : empty stack.
    setup("]", 0, 0, 0);
    release_reset();
    run_to_halt("t6", 100);
    check_val("t6_error", error, 1);

    // ",." with slow IO and enable dropped during the read.
    setup(",.", 0, 10, 0);
    io_in_val = 8'h5A;
    release_reset();
    n = 0;
    while (!read_io && n < 50) begin
      @(negedge clock);
      n++;
    end
    check_val("t7_io_seen", read_io, 1);
    enable = 1'b0;
    n = 0;
    while (io_rd_done == 0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    check_val("t7_io_hold_cycles", io_rd_cycles, 11);
    repeat (5) @(negedge clock);
    check_val("t7_idle_read_prog", read_prog, 0);
    check_val("t7_idle_prog_reads", prog_rd_cnt, 1);
    check_val("t7_idle_halted", halted, 0);
    enable = 1'b1;
    run_to_halt("t7", 200);
    check_val("t7_io_val", io_out_last, 8'h5A);
    check_val("t7_wd_val", wd_val[0], 8'h5A);

    // "+>" with a slow write : reset mid write_data drops the strobe at once.
    setup("+>", 0, 0, 30);
    release_reset();
    n = 0;
    while (!write_data && n < 50) begin
      @(negedge clock);
      n++;
    end
    check_val("t8_wd_seen", write_data, 1);
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check_val("t8_rst_strobes", {read_prog, read_data, write_data, read_io, write_io}, 0);
    check_val("t8_no_write", wd_cnt, 0);

    check_val("bus_onehot", onehot_err, 0);
    check_val("bus_stable", stab_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
